// File: rtl/exec_stage_mc_if.sv
// rtl/exec_stage_mc_if.sv - operand, control and EX/MEM buffer bundle for the execute stage
interface exec_stage_mc_if #(
  parameter int N    = 24,
  parameter int RA_W = 4,
  parameter int BW   = 2*N+RA_W+12
);
  logic            en;
  logic            flush;
  logic [N-1:0]    rd1;
  logic [N-1:0]    rd2;
  logic [N-1:0]    rd3;
  logic [N-1:0]    pc;
  logic [N-1:0]    imm;
  logic [N-1:0]    aluOut;
  logic [N-1:0]    result;
  logic [1:0]      Fa;
  logic [1:0]      Fb;
  logic            aSrc;
  logic            immSrc;
  logic [3:0]      aluControl;
  logic [RA_W-1:0] Rc;
  logic            branchFlag;
  logic            memWrite;
  logic            memToReg;
  logic            regWrite;
  logic [1:0]      opType;
  logic [3:0]      opCode;
  logic            stall;
  logic            divZero;
  logic [BW-1:0]   bufferOut;

  modport master (
    output en, flush, rd1, rd2, rd3, pc, imm, aluOut, result, Fa, Fb, aSrc, immSrc,
           aluControl, Rc, branchFlag, memWrite, memToReg, regWrite, opType, opCode,
    input  stall, divZero, bufferOut
  );

  modport slave (
    input  en, flush, rd1, rd2, rd3, pc, imm, aluOut, result, Fa, Fb, aSrc, immSrc,
           aluControl, Rc, branchFlag, memWrite, memToReg, regWrite, opType, opCode,
    output stall, divZero, bufferOut
  );
endinterface

// File: rtl/exec_stage_mc.sv
// rtl/exec_stage_mc.sv - execute stage: forwarding, single-cycle ALU, iterative MUL/DIV/REM
module exec_stage_mc #(
  parameter int N    = 24,
  parameter int RA_W = 4,
  parameter int BW   = 2*N+RA_W+12
) (
  input  logic           clk,
  input  logic           rst,
  exec_stage_mc_if.slave ex
);
  localparam int SW = $clog2(N);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  state_t state, nextState;

  logic [SW-1:0]   count;
  logic [N-1:0]    fwdA, fwdB, srcA, srcB, aluRes, magA, magB, mcRes;
  logic            isMc, mcAccept;
  logic [BW-1:0]   liveBuf, bubbleBuf, mcBuf;

  logic [3:0]      mcOp;
  logic [N-1:0]    opA, opB, acc, quo, heldA, heldRd3;
  logic            negRes, negRem, divByZero;
  logic [RA_W-1:0] heldRc;
  logic [3:0]      heldCtl, heldOpCode;
  logic [1:0]      heldOpType;
  logic [N:0]      trial, diff;
  logic            quoBit;

  function automatic logic [BW-1:0] pack(input logic [1:0] ot, input logic [3:0] oc,
                                         input logic [N-1:0] r, input logic [3:0] ctl,
                                         input logic [RA_W-1:0] rc, input logic [N-1:0] d);
    return {ot, oc, r, (r == '0), r[N-1], ctl, rc, d};
  endfunction

  always_comb begin
    fwdA = ex.rd1;
    fwdB = ex.rd2;
    case (ex.Fa)
      2'd1:    fwdA = ex.aluOut;
      2'd2:    fwdA = ex.result;
      default: fwdA = ex.rd1;
    endcase
    case (ex.Fb)
      2'd1:    fwdB = ex.aluOut;
      2'd2:    fwdB = ex.result;
      default: fwdB = ex.rd2;
    endcase
    srcA = ex.aSrc   ? ex.pc  : fwdA;
    srcB = ex.immSrc ? ex.imm : fwdB;
  end

  always_comb begin
    aluRes = srcB;
    case (ex.aluControl)
      4'd0:    aluRes = srcA - srcB;
      4'd1:    aluRes = srcA + srcB;
      4'd2:    aluRes = srcA & srcB;
      4'd3:    aluRes = srcA | srcB;
      4'd4:    aluRes = srcA ^ srcB;
      4'd5:    aluRes = srcA << srcB[SW-1:0];
      4'd6:    aluRes = srcA >> srcB[SW-1:0];
      4'd7:    aluRes = $signed(srcA) >>> srcB[SW-1:0];
      default: aluRes = srcB;
    endcase
  end

  assign isMc     = (ex.aluControl == 4'd8) | (ex.aluControl == 4'd9) | (ex.aluControl == 4'd10);
  assign mcAccept = (state == IDLE) & ex.en & isMc & ~ex.flush;
  // Gated by rst so the stall line reads 0 throughout reset, not just after the first edge.
  assign ex.stall = rst & (mcAccept | (state == BUSY));

  assign magA = srcA[N-1] ? -srcA : srcA;
  assign magB = srcB[N-1] ? -srcB : srcB;

  // Restoring-divide step: acc holds the partial remainder, quo shifts dividend out and quotient in.
  assign trial  = {acc, quo[N-1]};
  assign diff   = trial - {1'b0, opB};
  assign quoBit = ~diff[N];

  always_comb begin
    case (mcOp)
      4'd8:    mcRes = negRes ? -acc : acc;
      4'd9:    mcRes = divByZero ? '1 : (negRes ? -quo : quo);
      default: mcRes = divByZero ? heldA : (negRem ? -acc : acc);
    endcase
  end

  assign liveBuf   = pack(ex.opType, ex.opCode, aluRes,
                          {ex.branchFlag, ex.memWrite, ex.memToReg, ex.regWrite}, ex.Rc, ex.rd3);
  assign bubbleBuf = pack(ex.opType, ex.opCode, aluRes, 4'b0000, ex.Rc, ex.rd3);
  assign mcBuf     = pack(heldOpType, heldOpCode, mcRes, heldCtl, heldRc, heldRd3);

  always_comb begin
    nextState = state;
    if (ex.flush) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE:    if (mcAccept) nextState = BUSY;
        BUSY:    if (count == SW'(N-1)) nextState = DONE;
        DONE:    nextState = IDLE;
        default: nextState = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex.bufferOut <= '0;
      ex.divZero   <= 1'b0;
      count        <= '0;
      mcOp         <= '0;
      opA          <= '0;
      opB          <= '0;
      acc          <= '0;
      quo          <= '0;
      heldA        <= '0;
      heldRd3      <= '0;
      negRes       <= 1'b0;
      negRem       <= 1'b0;
      divByZero    <= 1'b0;
      heldRc       <= '0;
      heldCtl      <= '0;
      heldOpCode   <= '0;
      heldOpType   <= '0;
    end else begin
      ex.divZero <= 1'b0;
      if (ex.flush) begin
        ex.bufferOut <= '0;
        count        <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (mcAccept) begin
              mcOp         <= ex.aluControl;
              opA          <= magA;
              opB          <= magB;
              quo          <= magA;
              acc          <= '0;
              count        <= '0;
              heldA        <= srcA;
              negRes       <= srcA[N-1] ^ srcB[N-1];
              negRem       <= srcA[N-1];
              divByZero    <= (srcB == '0);
              heldRd3      <= ex.rd3;
              heldRc       <= ex.Rc;
              heldCtl      <= {ex.branchFlag, ex.memWrite, ex.memToReg, ex.regWrite};
              heldOpCode   <= ex.opCode;
              heldOpType   <= ex.opType;
              ex.bufferOut <= bubbleBuf;
            end else if (ex.en) begin
              ex.bufferOut <= liveBuf;
            end
          end
          BUSY: begin
            count        <= count + 1'b1;
            ex.bufferOut <= bubbleBuf;
            if (mcOp == 4'd8) begin
              if (opB[0]) acc <= acc + opA;
              opA <= opA << 1;
              opB <= opB >> 1;
            end else begin
              acc <= quoBit ? diff[N-1:0] : trial[N-1:0];
              quo <= {quo[N-2:0], quoBit};
            end
          end
          DONE: begin
            ex.bufferOut <= mcBuf;
            ex.divZero   <= divByZero & (mcOp != 4'd8);
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_exec_stage_mc.sv
// tb/tb_exec_stage_mc.sv - directed bench for exec_stage_mc with a cycle-level reference model
module tb_exec_stage_mc;
  localparam int N    = 24;
  localparam int RA_W = 4;
  localparam int BW   = 2*N+RA_W+12;
  localparam int SW   = $clog2(N);
  localparam int B0   = N+RA_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  exec_stage_mc_if #(.N(N), .RA_W(RA_W), .BW(BW)) ex();
  exec_stage_mc #(.N(N), .RA_W(RA_W), .BW(BW)) dut (.clk(clk), .rst(rst), .ex(ex.slave));

  int checks = 0;
  int errors = 0;
  bit chkOn  = 1'b0;

  logic [BW-1:0] expBuf, heldBuf;
  bit            expDz, heldDz, expBubble, expStall;
  int            mcLeft;

  logic [3:0]   vOp [0:9] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd6, 4'd7, 4'd7, 4'd1, 4'd11};
  logic [N-1:0] vA  [0:9] = '{24'hF0F0F0, 24'h0F0000, 24'hFFFF00, 24'h000001, 24'h000003,
                              24'h800000, 24'h800000, 24'h7FFFFF, 24'h7FFFFF, 24'h123456};
  logic [N-1:0] vB  [0:9] = '{24'h0FF00F, 24'h0000F0, 24'h00FFFF, 24'd23, 24'd33,
                              24'd4, 24'd4, 24'd22, 24'd1, 24'h00ABCD};
  logic [3:0]   mOp [0:5] = '{4'd8, 4'd8, 4'd9, 4'd10, 4'd9, 4'd10};
  logic [N-1:0] mA  [0:5] = '{24'h800000, 24'hFFFFF0, 24'd7, 24'd7, 24'h800000, 24'h800000};
  logic [N-1:0] mB  [0:5] = '{24'hFFFFFF, 24'hFFFFF0, 24'hFFFFFE, 24'hFFFFFE, 24'hFFFFFF, 24'hFFFFFF};

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit isMc(input logic [3:0] op);
    return (op == 4'd8) || (op == 4'd9) || (op == 4'd10);
  endfunction

  function automatic logic [N-1:0] refAlu(input logic [3:0] op, input logic [N-1:0] a,
                                          input logic [N-1:0] b);
    logic signed [N-1:0] sa, sb;
    logic [N-1:0] minV;
    sa = a;
    sb = b;
    minV = '0;
    minV[N-1] = 1'b1;
    case (op)
      4'd0: return a - b;
      4'd1: return a + b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[SW-1:0];
      4'd6: return a >> b[SW-1:0];
      4'd7: return sa >>> b[SW-1:0];
      4'd8: return sa * sb;
      4'd9: begin
        if (b == '0) return '1;
        if (a == minV && b == '1) return minV;
        return sa / sb;
      end
      4'd10: begin
        if (b == '0) return a;
        if (a == minV && b == '1) return '0;
        return sa % sb;
      end
      default: return b;
    endcase
  endfunction

  function automatic logic [BW-1:0] expPack(input logic [N-1:0] r);
    return {ex.opType, ex.opCode, r, (r == '0), r[N-1],
            ex.branchFlag, ex.memWrite, ex.memToReg, ex.regWrite, ex.Rc, ex.rd3};
  endfunction

  function automatic logic [N-1:0] resOf(input logic [BW-1:0] b);
    return b[B0+6 +: N];
  endfunction

  // Reference model: mcLeft counts edges until a multi-cycle result lands in the buffer.
  always @(posedge clk or negedge rst) begin
    logic [N-1:0] a, b;
    if (!rst) begin
      expBuf = '0; expDz = 1'b0; expBubble = 1'b0; mcLeft = 0;
    end else begin
      expDz = 1'b0;
      expBubble = 1'b0;
      a = ex.aSrc ? ex.pc : (ex.Fa == 2'd1 ? ex.aluOut : ex.Fa == 2'd2 ? ex.result : ex.rd1);
      b = ex.immSrc ? ex.imm : (ex.Fb == 2'd1 ? ex.aluOut : ex.Fb == 2'd2 ? ex.result : ex.rd2);
      if (ex.flush) begin
        expBuf = '0; mcLeft = 0;
      end else if (mcLeft > 1) begin
        mcLeft--; expBubble = 1'b1;
      end else if (mcLeft == 1) begin
        expBuf = heldBuf; expDz = heldDz; mcLeft = 0;
      end else if (ex.en) begin
        if (isMc(ex.aluControl)) begin
          heldBuf = expPack(refAlu(ex.aluControl, a, b));
          heldDz = (ex.aluControl != 4'd8) && (b == '0);
          mcLeft = N + 1;
          expBubble = 1'b1;
        end else begin
          expBuf = expPack(refAlu(ex.aluControl, a, b));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst && chkOn) begin
      expStall = (mcLeft == 0 && ex.en && isMc(ex.aluControl) && !ex.flush) || (mcLeft > 1);
      check("stall", BW'(ex.stall), BW'(expStall));
      check("divZero", BW'(ex.divZero), BW'(expDz));
      if (expBubble) check("bubbleCtl", BW'(ex.bufferOut[B0 +: 4]), '0);
      else           check("bufferOut", ex.bufferOut, expBuf);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    ex.en = 1'b1; ex.flush = 1'b0;
    ex.rd1 = a; ex.rd2 = b; ex.rd3 = a ^ 24'h5A5A5A;
    ex.pc = '0; ex.imm = '0; ex.aluOut = '0; ex.result = '0;
    ex.Fa = 2'd0; ex.Fb = 2'd0; ex.aSrc = 1'b0; ex.immSrc = 1'b0;
    ex.aluControl = op; ex.Rc = op;
    ex.branchFlag = op[2]; ex.memWrite = op[1]; ex.memToReg = op[0]; ex.regWrite = 1'b1;
    ex.opType = 2'b10; ex.opCode = ~op;
  endtask

  task automatic runMc(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                       output logic [N-1:0] res, output logic dz);
    int cnt;
    drive(op, a, b);
    #1;
    cnt = 0;
    while (ex.stall && cnt < 200) begin
      cnt++;
      step();
    end
    check("mcStallCycles", BW'(cnt), BW'(N + 1));
    check("mcBubbleRegWrite", BW'(ex.bufferOut[B0]), '0);
    step();
    drive(4'd1, 24'd1, 24'd1);
    res = resOf(ex.bufferOut);
    dz = ex.divZero;
  endtask

  initial begin
    logic [N-1:0] r;
    logic dz;
    drive(4'd8, 24'd7, 24'd3);
    step();
    step();
    check("rstBuffer", ex.bufferOut, '0);
    check("rstStall", BW'(ex.stall), '0);
    check("rstDivZero", BW'(ex.divZero), '0);
    drive(4'd1, 24'd2, 24'd2);
    rst = 1'b1;
    chkOn = 1'b1;
    step();
    check("addRes", BW'(resOf(ex.bufferOut)), BW'(24'd4));
    check("addZeroNeg", BW'(ex.bufferOut[B0+4 +: 2]), '0);
    check("passRc", BW'(ex.bufferOut[N +: RA_W]), BW'(4'd1));
    check("passRd3", BW'(ex.bufferOut[N-1:0]), BW'(24'h5A5A58));
    check("passOpCode", BW'(ex.bufferOut[B0+6+N +: 4]), BW'(4'hE));
    check("passOpType", BW'(ex.bufferOut[B0+10+N +: 2]), BW'(2'b10));

    drive(4'd0, 24'd2, 24'd0); ex.imm = 24'd2; ex.immSrc = 1'b1;
    step();
    check("subImmZero", BW'({resOf(ex.bufferOut), ex.bufferOut[B0+5]}), BW'({24'd0, 1'b1}));
    drive(4'd0, 24'd0, 24'd2); ex.pc = 24'd1; ex.aSrc = 1'b1;
    step();
    check("subPcNeg", BW'({resOf(ex.bufferOut), ex.bufferOut[B0+4]}), BW'({24'hFFFFFF, 1'b1}));

    drive(4'd0, 24'd0, 24'd0); ex.Fa = 2'd1; ex.aluOut = 24'd10; ex.Fb = 2'd2; ex.result = 24'd5;
    step();
    check("fwdAluRes", BW'(resOf(ex.bufferOut)), BW'(24'd5));
    ex.Fa = 2'd3;
    step();
    check("fwdFa3", BW'(resOf(ex.bufferOut)), BW'(24'hFFFFFB));

    for (int i = 0; i < 10; i++) begin
      drive(vOp[i], vA[i], vB[i]);
      step();
      if (i == 4) check("sllLowBits", BW'(resOf(ex.bufferOut)), BW'(24'd6));
      if (i == 6) check("sraMin", BW'(resOf(ex.bufferOut)), BW'(24'hF80000));
      if (i == 8) check("addWrap", BW'(resOf(ex.bufferOut)), BW'(24'h800000));
    end

    ex.en = 1'b0; ex.rd1 = 24'd99; ex.aluControl = 4'd9;
    step();
    step();
    check("enHold", BW'(resOf(ex.bufferOut)), BW'(24'h00ABCD));

    runMc(4'd8, 24'd7, 24'hFFFFFD, r, dz);
    check("mulRes", BW'(r), BW'(24'hFFFFEB));
    check("mulNeg", BW'(ex.bufferOut[B0+4]), BW'(1'b1));
    runMc(4'd9, 24'hFFFFF9, 24'd2, r, dz);
    check("divRes", BW'(r), BW'(24'hFFFFFD));
    runMc(4'd10, 24'hFFFFF9, 24'd2, r, dz);
    check("remRes", BW'(r), BW'(24'hFFFFFF));
    runMc(4'd9, 24'd5, 24'd0, r, dz);
    check("divZeroRes", BW'(r), BW'(24'hFFFFFF));
    check("divZeroPulse", BW'(dz), BW'(1'b1));
    step();
    check("divZeroClear", BW'(ex.divZero), '0);
    runMc(4'd10, 24'd5, 24'd0, r, dz);
    check("remZeroRes", BW'(r), BW'(24'd5));
    runMc(4'd9, 24'h800000, 24'hFFFFFF, r, dz);
    check("divMinRes", BW'({r, dz}), BW'({24'h800000, 1'b0}));
    for (int i = 0; i < 6; i++) begin
      runMc(mOp[i], mA[i], mB[i], r, dz);
    end

    drive(4'd9, 24'd100, 24'd7);
    repeat (5) step();
    ex.flush = 1'b1;
    step();
    check("flushBuffer", ex.bufferOut, '0);
    check("flushStall", BW'(ex.stall), '0);
    drive(4'd1, 24'd3, 24'd4);
    step();
    check("afterFlush", BW'(resOf(ex.bufferOut)), BW'(24'd7));

    drive(4'd9, 24'd100, 24'd7);
    repeat (3) step();
    check("preRstStall", BW'(ex.stall), BW'(1'b1));
    rst = 1'b0;
    #1;
    check("asyncRstBuffer", ex.bufferOut, '0);
    check("asyncRstStall", BW'(ex.stall), '0);
    check("asyncRstDivZero", BW'(ex.divZero), '0);
    drive(4'd1, 24'd3, 24'd4);
    step();
    rst = 1'b1;
    step();
    check("postRstAdd", BW'(resOf(ex.bufferOut)), BW'(24'd7));
    step();
    chkOn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
